oa_tree_n: RTL
==============

// Module: oa_tree_n
// PURPOSE
//  Parametrised N-input online (MSD-first, radix-2 signed-digit) adder tree for DSLOT-NN neuron sums.
//  Builds a ceil(log2 N)-level balanced tree of OA cells. Odd operands at any level take delay-matched pass-through chains.
//  A frame FSM accepts N_DIGITS digits, injects zero flush digits and tags output digits with valid/start/last.
//  Detects broken frames and aborts them.
// PARAMETERS
//  N_INPUTS   9  operand count, >=2
//  N_DIGITS   8  fractional digits per input frame, >=2
//  OA_DELAY   2  online delay (cycles) of one OA cell
//  (derived) L = clog2(N_INPUTS); TREE_LAT = L*OA_DELAY; OUT_DIGITS = N_DIGITS + L
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, synchronous, active-high
//  in_valid   in   1         digit slice on x_p/x_n valid this cycle
//  in_start   in   1         slice is MSD (index 1) of a new frame
//  x_p        in   N_INPUTS  positive digit bits, one per operand
//  x_n        in   N_INPUTS  negative digit bits; digit = x_p[i]-x_n[i], (1,1)=0
//  in_ready   out  1         block accepts a slice this cycle
//  z_p, z_n   out  1         result digit, value z_p-z_n
//  out_valid  out  1         z is a digit of the current output frame
//  out_start  out  1         z is output MSD (index 1)
//  out_last   out  1         z is output index OUT_DIGITS
//  frame_err  out  1         1-cycle pulse: frame aborted
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1. FSM=IDLE. All OA state, pass-through and tag registers cleared.
//  Digit k of an operand has weight 2^-k. Operands are in (-1,1).
//  OA cell: output at cycle t = digit (t-OA_DELAY) of (a+b)/2.
//  Pass-through for an unpaired operand = (a+0)/2 = shift-register chain of OA_DELAY+1 stages, reset 0.
//  Result: value(z frame) = sum(x_i)/2^L, exact over OUT_DIGITS digits.
//  FSM IDLE: in_ready=1. Tree fed zero digits.
//    - in_valid & in_start -> STREAM, dcnt=1.
//    - in_valid without in_start is ignored.
//  FSM STREAM: in_ready=1. Tree fed x.
//    - dcnt increments per accepted slice.
//    - After slice N_DIGITS -> FLUSH.
//  FSM FLUSH: in_ready=0 for exactly L cycles. Zeros fed to the tree. Then -> IDLE.
//  Frame period = N_DIGITS+L cycles. A new in_start is accepted the first IDLE cycle, so back-to-back frames give contiguous out_valid.
//  Output tags: a valid/start/last tag pipeline of depth TREE_LAT runs alongside the tree.
//    - out_start asserts TREE_LAT cycles after the accepted in_start cycle.
//    - out_valid stays high for OUT_DIGITS consecutive cycles; out_last is on the final one.
//  Abort: in STREAM with (!in_valid) or (in_valid & in_start) ->
//    - frame_err=1 for 1 cycle; FSM -> IDLE.
//    - Next cycle: all OA state, chains and tags are synchronously cleared.
//    - out_valid drops and out_last is never asserted for the aborted frame.
//    - An in_start causing the abort is not accepted; the sender re-sends it.
//  rst mid-frame: same clearing as reset; no frame_err.
//  in_valid ignored when in_ready=0. x may be X when not accepted; tree sees zeros.
// TESTING (N_INPUTS=9, N_DIGITS=8, OA_DELAY=2: L=4, TREE_LAT=8, OUT_DIGITS=12)
//  1. All operands 0, start at cycle 0 -> z value 0; out_start@8, out_valid cycles 8..19, out_last@19.
//  2. All 9 operands = +0.5 (digit1=+1) -> reconstructed z = 9/32.
//  3. x1=+0.5, x2=-0.5, x3..x9=+0.25 -> z = 7/64. Operands use (1,1) zero digits throughout -> same result.
//  4. All digits +1 (255/256 each) -> z = 9*255/4096. All -1 -> z = -9*255/4096.
//  5. Two frames at cycles 0 and 12 -> in_ready low 8..11, out_valid high 8..31, out_start@8,20, out_last@19,31.
//  6. in_valid dropped at cycle 4 of a frame -> frame_err@4, out_valid never rises. New frame at 6 -> out_start@14, correct sum.
//     rst at cycle 10 of a frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/oa_tree_n.sv
// N-input online (MSD-first, radix-2 signed-digit) adder tree with frame control.
// Each level halves the operand count; the result frame carries sum(x)/2^L.

module oa_tree_n_cell #(
  parameter int DELAY = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic a_p,
  input  logic a_n,
  input  logic b_p,
  input  logic b_n,
  output logic z_p,
  output logic z_n
);

  // s_reg holds x_j+y_j of the previous digit; the current digits act as lookahead.
  logic [2:0] s_reg;
  logic [2:0] w_reg;
  logic [2:0] s_new;
  logic [2:0] t;
  logic [2:0] w;
  logic [2:0] zv;
  logic       nonneg;
  logic [DELAY-2:0] zp_pipe;
  logic [DELAY-2:0] zn_pipe;

  assign s_new  = {2'b00, a_p} - {2'b00, a_n} + {2'b00, b_p} - {2'b00, b_n};
  assign nonneg = !a_n && !b_n;

  // Split s = 2t + w so that w_(j-1) + t_j always stays a single signed digit.
  always_comb begin
    t = 3'd0;
    w = 3'd0;
    case (s_reg)
      3'd2: t = 3'd1;
      3'd1: begin
        if (nonneg) begin
          t = 3'd1;
          w = 3'b111;
        end else begin
          w = 3'd1;
        end
      end
      3'b111: begin
        if (nonneg) begin
          w = 3'b111;
        end else begin
          t = 3'b111;
          w = 3'd1;
        end
      end
      3'b110: t = 3'b111;
      default: ;
    endcase
  end

  assign zv = w_reg + t;

  always_ff @(posedge clk) begin
    if (clr) begin
      s_reg   <= '0;
      w_reg   <= '0;
      zp_pipe <= '0;
      zn_pipe <= '0;
    end else begin
      s_reg      <= s_new;
      w_reg      <= w;
      zp_pipe[0] <= (zv == 3'd1);
      zn_pipe[0] <= (zv == 3'b111);
      for (int j = 1; j <= DELAY - 2; j++) begin
        zp_pipe[j] <= zp_pipe[j-1];
        zn_pipe[j] <= zn_pipe[j-1];
      end
    end
  end

  assign z_p = zp_pipe[DELAY-2];
  assign z_n = zn_pipe[DELAY-2];

endmodule

module oa_tree_n #(
  parameter int N_INPUTS = 9,
  parameter int N_DIGITS = 8,
  parameter int OA_DELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_start,
  input  logic [N_INPUTS-1:0] x_p,
  input  logic [N_INPUTS-1:0] x_n,
  output logic                in_ready,
  output logic                z_p,
  output logic                z_n,
  output logic                out_valid,
  output logic                out_start,
  output logic                out_last,
  output logic                frame_err
);

  localparam int L        = $clog2(N_INPUTS);
  localparam int TREE_LAT = L * OA_DELAY;
  localparam int DW       = $clog2(N_DIGITS + 1);
  localparam int FW       = $clog2(L + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  function automatic int lvl_cnt(input int lvl);
    int c;
    c = N_INPUTS;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  logic [1:0]    state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic [FW-1:0] fcnt_reg, fcnt_next;
  logic          abort;
  logic          feed;
  logic          tag_v, tag_s, tag_l;
  logic          clr;

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    fcnt_next  = fcnt_reg;
    abort      = 1'b0;
    feed       = 1'b0;
    tag_v      = 1'b0;
    tag_s      = 1'b0;
    tag_l      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_start) begin
          feed       = 1'b1;
          tag_v      = 1'b1;
          tag_s      = 1'b1;
          dcnt_next  = DW'(1);
          state_next = STREAM;
        end
      end
      STREAM: begin
        // A gap or a premature start breaks the frame; the start slice is not consumed.
        if (!in_valid || in_start) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          feed      = 1'b1;
          tag_v     = 1'b1;
          dcnt_next = dcnt_reg + DW'(1);
          if (dcnt_reg == DW'(N_DIGITS - 1)) begin
            fcnt_next  = '0;
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        tag_v     = 1'b1;
        fcnt_next = fcnt_reg + FW'(1);
        if (fcnt_reg == FW'(L - 1)) begin
          tag_l      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
      fcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  assign in_ready  = (state_reg != FLUSH);
  assign frame_err = abort && !rst;
  assign clr       = rst || abort;

  // Level 0 holds canonical digits: (1,1) folds to zero, rejected slices become zero.
  logic [L:0][N_INPUTS-1:0] tp;
  logic [L:0][N_INPUTS-1:0] tn;
  logic                     unused_tree;

  assign tp[0] = feed ? (x_p & ~x_n) : '0;
  assign tn[0] = feed ? (x_n & ~x_p) : '0;

  for (genvar gl = 0; gl < L; gl++) begin : g_lvl
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_node
      if (2 * gi + 1 < lvl_cnt(gl)) begin : g_oa
        oa_tree_n_cell #(.DELAY(OA_DELAY)) u_cell (
          .clk (clk),
          .clr (clr),
          .a_p (tp[gl][2*gi]),
          .a_n (tn[gl][2*gi]),
          .b_p (tp[gl][2*gi+1]),
          .b_n (tn[gl][2*gi+1]),
          .z_p (tp[gl+1][gi]),
          .z_n (tn[gl+1][gi])
        );
      end else if (2 * gi < lvl_cnt(gl)) begin : g_pass
        // (a+0)/2 is a one-digit shift, so one stage more than an OA cell.
        logic [OA_DELAY:0] cp_reg;
        logic [OA_DELAY:0] cn_reg;
        always_ff @(posedge clk) begin
          if (clr) begin
            cp_reg <= '0;
            cn_reg <= '0;
          end else begin
            cp_reg <= {cp_reg[OA_DELAY-1:0], tp[gl][2*gi]};
            cn_reg <= {cn_reg[OA_DELAY-1:0], tn[gl][2*gi]};
          end
        end
        assign tp[gl+1][gi] = cp_reg[OA_DELAY];
        assign tn[gl+1][gi] = cn_reg[OA_DELAY];
      end else begin : g_none
        assign tp[gl+1][gi] = 1'b0;
        assign tn[gl+1][gi] = 1'b0;
      end
    end
  end

  assign unused_tree = ^{tp, tn};
  assign z_p = tp[L][0];
  assign z_n = tn[L][0];

  logic [TREE_LAT-1:0] tv_reg, ts_reg, tl_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      tv_reg <= '0;
      ts_reg <= '0;
      tl_reg <= '0;
    end else begin
      tv_reg <= {tv_reg[TREE_LAT-2:0], tag_v};
      ts_reg <= {ts_reg[TREE_LAT-2:0], tag_s};
      tl_reg <= {tl_reg[TREE_LAT-2:0], tag_l};
    end
  end

  assign out_valid = tv_reg[TREE_LAT-1];
  assign out_start = ts_reg[TREE_LAT-1];
  assign out_last  = tl_reg[TREE_LAT-1];

endmodule
